// File: rtl/sdr_frame_tx.sv
// SDR bit engine: serialises one frame MSB-first onto SDA on SCL falling-edge strobes,
// then appends a T-bit, samples an ACK, or stops, depending on the latched mode.
module sdr_frame_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_sdr_ctrl_clk,
    input  logic                  i_sdr_ctrl_rst_n,
    input  logic                  i_scl_neg_edge,
    input  logic                  i_scl_pos_edge,
    input  logic                  i_tx_en,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [1:0]            i_tx_mode,
    input  logic                  i_sda,
    output logic                  o_sda,
    output logic                  o_sda_oe,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ack
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] MODE_DATA_T   = 2'b00;
    localparam logic [1:0] MODE_ADDR_ACK = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_NEG,
        SHIFT,
        NINTH,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic                  sda_q, sda_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ack_q, ack_d;
    logic                  ack_seen_q, ack_seen_d;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        sda_d      = sda_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_d      = ack_q;
        ack_seen_d = ack_seen_q;

        case (state_q)
            IDLE: begin
                if (i_tx_en) begin
                    data_d     = i_tx_data;
                    mode_d     = i_tx_mode;
                    cnt_d      = CW'(DATA_WIDTH - 1);
                    busy_d     = 1'b1;
                    ack_d      = 1'b0;
                    ack_seen_d = 1'b0;
                    state_d    = WAIT_NEG;
                end
            end

            WAIT_NEG: begin
                if (i_scl_neg_edge) begin
                    sda_d   = data_q[DATA_WIDTH-1];
                    oe_d    = 1'b1;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (i_scl_neg_edge) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                        sda_d = data_q[cnt_q - CW'(1)];
                    end else if (mode_q == MODE_DATA_T) begin
                        // T-bit makes the total count of ones (payload + T) odd.
                        sda_d   = ~^data_q;
                        state_d = NINTH;
                    end else if (mode_q == MODE_ADDR_ACK) begin
                        oe_d    = 1'b0;
                        sda_d   = 1'b1;
                        state_d = NINTH;
                    end else begin
                        oe_d    = 1'b0;
                        sda_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end

            NINTH: begin
                // A falling strobe takes priority; a coincident rising strobe is dropped.
                if (i_scl_neg_edge) begin
                    oe_d    = 1'b0;
                    sda_d   = 1'b1;
                    state_d = FINISH;
                end else if (i_scl_pos_edge && mode_q == MODE_ADDR_ACK && !ack_seen_q) begin
                    ack_d      = ~i_sda;
                    ack_seen_d = 1'b1;
                end
            end

            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            cnt_q      <= '0;
            mode_q     <= '0;
            sda_q      <= 1'b1;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
            ack_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            sda_q      <= sda_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
            ack_seen_q <= ack_seen_d;
        end
    end

    assign o_sda    = sda_q;
    assign o_sda_oe = oe_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_ack    = ack_q;

endmodule

// File: tb/tb_sdr_frame_tx.sv
// Scoreboard bench for sdr_frame_tx: the driver queues expected SDA bits and completions
// as it issues SCL strobes; a monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_sdr_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       neg = 1'b0;
    logic       pos = 1'b0;
    logic       tx_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] tx_mode = 2'b00;
    logic       sda_in = 1'b1;
    logic       sda_out, sda_oe, busy, done, ack;

    sdr_frame_tx #(.DATA_WIDTH(8)) dut (
        .i_sdr_ctrl_clk   (clk),
        .i_sdr_ctrl_rst_n (rst_n),
        .i_scl_neg_edge   (neg),
        .i_scl_pos_edge   (pos),
        .i_tx_en          (tx_en),
        .i_tx_data        (tx_data),
        .i_tx_mode        (tx_mode),
        .i_sda            (sda_in),
        .o_sda            (sda_out),
        .o_sda_oe         (sda_oe),
        .o_busy           (busy),
        .o_done           (done),
        .o_ack            (ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ack;
        int   lat;
    } done_exp_t;

    logic [1:0] bit_q[$];
    done_exp_t  done_q[$];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: cycles since the last falling strobe decide which comparison applies.
    int         mon_since = 1000;
    logic [1:0] mon_prev = 2'b00;
    bit         mon_prev_valid = 1'b0;
    logic [1:0] mon_exp;
    done_exp_t  mon_done;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_since      = 1000;
                mon_prev_valid = 1'b0;
            end else begin
                if (mon_since < 1000) mon_since++;
                if (mon_since == 1) begin
                    if (bit_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_bit: got %b with no expected entry", {sda_oe, sda_out});
                    end else begin
                        mon_exp = bit_q.pop_front();
                        check("bit_oe_sda", {30'd0, sda_oe, sda_out}, {30'd0, mon_exp});
                    end
                end else if (mon_prev_valid) begin
                    check("hold_between_falls", {30'd0, sda_oe, sda_out}, {30'd0, mon_prev});
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
                    end else begin
                        mon_done = done_q.pop_front();
                        check("done_latency", mon_since, mon_done.lat);
                        check("done_ack", {31'd0, ack}, {31'd0, mon_done.ack});
                        check("busy_at_done", {31'd0, busy}, 32'd0);
                    end
                end
                mon_prev       = {sda_oe, sda_out};
                mon_prev_valid = 1'b1;
                if (neg) mon_since = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept(input logic [1:0] m, input logic [7:0] d, input bit hold);
        tx_mode = m;
        tx_data = d;
        tx_en   = 1'b1;
        tick(1);
        if (!hold) tx_en = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        tick(1);
    endtask

    task automatic fall(input logic [1:0] e);
        bit_q.push_back(e);
        neg = 1'b1;
        tick(1);
        neg = 1'b0;
        tick(2);
    endtask

    task automatic rise();
        pos = 1'b1;
        tick(1);
        pos = 1'b0;
        tick(2);
    endtask

    // Drives one whole frame's worth of SCL strobes; expectations are hand-supplied.
    task automatic run_bits(input logic [1:0] m, input logic [7:0] d, input logic exp_t,
                            input logic ack_sda, input logic exp_ack,
                            input int stall_at, input bit both_end);
        done_exp_t de;
        for (int i = 0; i < 8; i++) begin
            fall({1'b1, d[7-i]});
            rise();
            if (i == stall_at) tick(16);
        end
        if (m[1]) begin
            de.ack = 1'b0;
            de.lat = 1;
            done_q.push_back(de);
            fall(2'b01);
        end else begin
            fall((m == 2'b00) ? {1'b1, exp_t} : 2'b01);
            sda_in = ack_sda;
            if (!both_end) rise();
            de.ack = exp_ack;
            de.lat = 2;
            done_q.push_back(de);
            if (both_end) begin
                bit_q.push_back(2'b01);
                neg = 1'b1;
                pos = 1'b1;
                tick(1);
                neg = 1'b0;
                pos = 1'b0;
                tick(2);
            end else begin
                fall(2'b01);
            end
            sda_in = 1'b1;
        end
        tick(4);
    endtask

    initial begin
        tick(2);
        check("rst_sda", {31'd0, sda_out}, 32'd1);
        check("rst_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Mode 00: A5 has four ones -> T=1; stall while SCL high after bit 3.
        accept(2'b00, 8'hA5, 1'b0);
        run_bits(2'b00, 8'hA5, 1'b1, 1'b1, 1'b0, 3, 1'b0);
        check("oe_after_a5", {31'd0, sda_oe}, 32'd0);
        // Mode 00: 07 has three ones -> T=0.
        accept(2'b00, 8'h07, 1'b0);
        run_bits(2'b00, 8'h07, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        // Mode 00: 00 -> T=1, with a mid-frame stall.
        accept(2'b00, 8'h00, 1'b0);
        run_bits(2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 4, 1'b0);

        // Mode 01: NACK then ACK.
        accept(2'b01, 8'h7E, 1'b0);
        run_bits(2'b01, 8'h7E, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        accept(2'b01, 8'h7E, 1'b0);
        run_bits(2'b01, 8'h7E, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        check("ack_held_after_done", {31'd0, ack}, 32'd1);

        // Mode 10 with i_tx_en held and data changed after latch; ack cleared on acceptance.
        accept(2'b10, 8'hC3, 1'b1);
        tx_data = 8'h3C;
        run_bits(2'b10, 8'hC3, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        check("back_to_back_busy", {31'd0, busy}, 32'd1);
        tx_en = 1'b0;
        run_bits(2'b10, 8'h3C, 1'b0, 1'b1, 1'b0, -1, 1'b0);

        // Mode 11 behaves as payload-only.
        accept(2'b11, 8'h81, 1'b0);
        run_bits(2'b11, 8'h81, 1'b0, 1'b1, 1'b0, -1, 1'b0);

        // Mode 01 with both strobes on the last edge: SDA low at that rise must be ignored.
        accept(2'b01, 8'h5A, 1'b0);
        run_bits(2'b01, 8'h5A, 1'b0, 1'b0, 1'b0, -1, 1'b1);

        // Asynchronous reset after the 4th bit of a mode 00 frame.
        accept(2'b00, 8'h0F, 1'b0);
        for (int i = 0; i < 4; i++) begin
            fall({1'b1, 1'b0});
            rise();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_oe", {31'd0, sda_oe}, 32'd0);
        check("async_rst_sda", {31'd0, sda_out}, 32'd1);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        tick(2);
        #2;
        rst_n = 1'b1;
        tick(3);
        // Clean frame from the MSB: 96 has four ones -> T=1.
        accept(2'b00, 8'h96, 1'b0);
        run_bits(2'b00, 8'h96, 1'b1, 1'b1, 1'b0, -1, 1'b0);

        tick(10);
        check("bit_queue_drained", bit_q.size(), 32'd0);
        check("done_queue_drained", done_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdr_frame_tx.md
Name: sdr_frame_tx

Overview:
- SDR bit engine sitting directly downstream of scl_generation in the I3C controller datapath.
- Consumes the one-cycle o_scl_neg_edge / o_scl_pos_edge strobes and serialises one 8-bit frame MSB-first onto SDA.
- Appends the 9th bit according to mode: T-bit (odd parity), ACK sampling, or none.
- Reports completion and ACK status to the SDR controller FSM.

Parameters:
- DATA_WIDTH, 8, frame payload width; bit counter is $clog2(DATA_WIDTH) bits.

Ports:
- i_sdr_ctrl_clk  in  1  system clock
- i_sdr_ctrl_rst_n  in  1  asynchronous active-low reset
- i_scl_neg_edge  in  1  one-cycle pulse, SCL falling edge (from scl_generation)
- i_scl_pos_edge  in  1  one-cycle pulse, SCL rising edge (from scl_generation)
- i_tx_en  in  1  frame start request, level, sampled only in IDLE
- i_tx_data  in  DATA_WIDTH  payload, latched when i_tx_en is accepted
- i_tx_mode  in  2  00 data+T-bit, 01 address+ACK, 10 payload only, 11 treated as 10
- i_sda  in  1  synchronised SDA line value
- o_sda  out  1  SDA drive value
- o_sda_oe  out  1  1 = drive o_sda, 0 = release (pull-up)
- o_busy  out  1  high from acceptance until return to IDLE
- o_done  out  1  one-cycle completion pulse
- o_ack  out  1  1 = target ACKed (SDA low at 9th rising edge); valid from o_done until next acceptance

Behaviour:
- Reset (async, immediate, also mid-frame): state IDLE; o_sda=1; o_sda_oe=0; o_busy=0; o_done=0; o_ack=0; shift register and counter cleared.
- States: IDLE, WAIT_NEG, SHIFT, NINTH, FINISH.
- IDLE:
  - i_tx_en=1 latches i_tx_data into the shift register and i_tx_mode into a mode register; counter=DATA_WIDTH-1.
  - o_busy=1 next cycle; go to WAIT_NEG.
  - o_ack is cleared on acceptance.
- WAIT_NEG: on i_scl_neg_edge, drive o_sda=data[MSB], o_sda_oe=1 (registered, visible the cycle after the strobe); go to SHIFT.
- SHIFT:
  - On each i_scl_neg_edge with counter>0: decrement, drive the next bit.
  - On i_scl_neg_edge with counter==0:
    - mode 00: drive T = ~^data (XNOR of the latched payload, total ones odd); go to NINTH.
    - mode 01: o_sda_oe=0, o_sda=1; go to NINTH.
    - mode 10/11: o_sda_oe=0, o_sda=1, pulse o_done; go to IDLE.
- NINTH:
  - mode 01: on i_scl_pos_edge, o_ack <= ~i_sda (sampled once only).
  - Any mode: next i_scl_neg_edge releases SDA (oe=0, sda=1); go to FINISH.
- FINISH: o_done=1 for exactly one cycle, o_busy=0 in the same cycle; go to IDLE.
- i_scl_pos_edge is ignored in all states except NINTH with mode 01.
- Data changes only on falling edges; payload bits are never changed while SCL is high.
- Latency, 8-bit frame:
  - Modes 00/01: first bit on the first falling edge after acceptance; o_done asserts 2 cycles after the 10th falling edge, counting the WAIT_NEG edge as the 1st.
  - Modes 10/11: o_done asserts the cycle after the 9th falling edge.
- i_tx_en while o_busy=1: ignored; i_tx_data/i_tx_mode changes are ignored after latch.
- i_tx_en held high through o_done: the next frame is accepted on the first IDLE cycle (back-to-back; no re-arm needed).
- Both strobes high in one cycle (illegal from the generator): the neg-edge action wins; the pos-edge is dropped.
- SCL stalled (no strobes): all outputs hold indefinitely; no timeout inside this block.

Test Plan:
- Mode 00, data 8'hA5 -> SDA after successive falling edges 1,0,1,0,0,1,0,1, then T=1 (four ones -> T=1); o_done single pulse; o_sda_oe=0 afterwards.
- Mode 00, data 8'h07 -> T=0; mode 00, data 8'h00 -> T=1; check across a 16-cycle SCL period with the stall inserted mid-frame -> bits unchanged during the stall.
- Mode 01, data 8'h7E, i_sda=0 at the 9th rising edge -> o_sda_oe=0 during the 9th bit, o_ack=1 at o_done. Repeat with i_sda=1 -> o_ack=0.
- Mode 10, data 8'hC3 -> exactly 8 bits driven; o_done the cycle after the 9th falling strobe; no 9th bit driven.
- i_tx_en held high, data changed to 8'h3C mid-frame -> first frame still 8'hC3; second frame 8'h3C starts immediately after o_done.
- Reset asserted after the 4th bit of mode 00 -> o_sda_oe=0, o_sda=1, o_busy=0 immediately (no clock edge); the next i_tx_en starts a clean frame from the MSB.
